// File: rtl/cmpgt_argmax.sv
`default_nettype none
//==============================================================================
// Module   : cmpgt_argmax (with cmpgt comparator)
// Purpose  : Streaming running-max / argmax over a valid/ready frame, built on
//            the dual-mode signed/unsigned greater-than comparator cmpgt.
// Revision : 1.0 - initial release
//==============================================================================

module cmpgt #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             gt
);
    always_comb begin
        if (is_signed) gt = ($signed(a) > $signed(b));
        else           gt = (a > b);
    end
endmodule

module cmpgt_argmax #(
    parameter int WIDTH = 16,
    parameter int IDXW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             is_signed,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_max,
    output logic [IDXW-1:0]  m_idx,
    output logic [IDXW-1:0]  m_count,
    output logic             m_ovf
);
    localparam logic [IDXW-1:0] c_one = IDXW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_s_ready;
    logic             r_m_valid;
    logic             r_mode;
    logic [WIDTH-1:0] r_max;
    logic [IDXW-1:0]  r_idx;
    logic [IDXW-1:0]  r_count;
    logic             r_ovf;
    logic             w_gt;

    cmpgt #(.WIDTH(WIDTH)) u_cmpgt (
        .a         (s_data),
        .b         (r_max),
        .is_signed (r_mode),
        .gt        (w_gt)
    );

    // Running max doubles as the result register; it is frozen while in OUTPUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
            r_mode    <= 1'b0;
            r_max     <= '0;
            r_idx     <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_s_ready <= 1'b1;
                    if (s_valid && r_s_ready) begin
                        r_max   <= s_data;
                        r_idx   <= '0;
                        r_count <= c_one;
                        r_ovf   <= 1'b0;
                        r_mode  <= is_signed;
                        if (s_last) begin
                            r_state   <= ST_OUTPUT;
                            r_s_ready <= 1'b0;
                            r_m_valid <= 1'b1;
                        end else begin
                            r_state <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (s_valid && r_s_ready) begin
                        if (w_gt) begin
                            r_max <= s_data;
                            r_idx <= r_count;
                        end
                        r_count <= r_count + c_one;
                        if (&r_count) r_ovf <= 1'b1;
                        if (s_last) begin
                            r_state   <= ST_OUTPUT;
                            r_s_ready <= 1'b0;
                            r_m_valid <= 1'b1;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (m_ready) begin
                        r_state   <= ST_IDLE;
                        r_s_ready <= 1'b1;
                        r_m_valid <= 1'b0;
                        r_ovf     <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_s_ready <= 1'b1;
                    r_m_valid <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready = r_s_ready;
    assign m_valid = r_m_valid;
    assign m_max   = r_max;
    assign m_idx   = r_idx;
    assign m_count = r_count;
    assign m_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cmpgt_argmax.sv
`default_nettype none
//==============================================================================
// Module   : tb_cmpgt_argmax
// Purpose  : Directed self-checking bench for cmpgt_argmax (IDXW=8 and IDXW=2).
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps

module tb_cmpgt_argmax;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        is_signed = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b0;

    logic        s_ready, m_valid, m_ovf;
    logic [15:0] m_max;
    logic [7:0]  m_idx, m_count;

    logic        s_ready_s, m_valid_s, m_ovf_s;
    logic [15:0] m_max_s;
    logic [1:0]  m_idx_s, m_count_s;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cmpgt_argmax #(.WIDTH(16), .IDXW(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .is_signed(is_signed),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_max(m_max), .m_idx(m_idx),
        .m_count(m_count), .m_ovf(m_ovf)
    );

    cmpgt_argmax #(.WIDTH(16), .IDXW(2)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .is_signed(is_signed),
        .s_valid(s_valid), .s_ready(s_ready_s), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid_s), .m_ready(m_ready), .m_max(m_max_s), .m_idx(m_idx_s),
        .m_count(m_count_s), .m_ovf(m_ovf_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic last, input logic sg);
        int n = 0;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_ready_timeout", 32'd0, 32'd1);
        s_valid   = 1'b1;
        s_data    = d;
        s_last    = last;
        is_signed = sg;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic consume();
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_max",   m_max, 0);
        check("rst_m_count", m_count, 0);
        check("rst_m_ovf",   m_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_s_ready", s_ready, 1);

        // Unsigned frame
        send(16'h0001, 0, 0);
        send(16'hFFFF, 0, 0);
        send(16'h0002, 1, 0);
        check("u_latency_valid", m_valid, 1);
        check("u_max",   m_max, 16'hFFFF);
        check("u_idx",   m_idx, 1);
        check("u_count", m_count, 3);
        check("u_ovf",   m_ovf, 0);
        consume();
        check("u_valid_drop", m_valid, 0);

        // Signed frame, same data
        send(16'h0001, 0, 1);
        send(16'hFFFF, 0, 1);
        send(16'h0002, 1, 1);
        check("s_valid", m_valid, 1);
        check("s_max",   m_max, 16'h0002);
        check("s_idx",   m_idx, 2);
        check("s_count", m_count, 3);
        consume();

        // Ties, earliest wins; mode toggle mid-frame ignored
        send(16'd5, 0, 0);
        send(16'd7, 0, 1);
        send(16'd7, 0, 1);
        send(16'd3, 1, 1);
        check("t_max",   m_max, 7);
        check("t_idx",   m_idx, 1);
        check("t_count", m_count, 4);
        consume();

        // Mode latch with data whose order depends on mode: unsigned picks 0x8000
        send(16'h0001, 0, 0);
        send(16'h8000, 1, 1);
        check("ml_max", m_max, 16'h8000);
        check("ml_idx", m_idx, 1);
        consume();

        // Single sample with backpressure
        send(16'h8000, 1, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_m_valid", m_valid, 1);
            check("bp_s_ready", s_ready, 0);
            check("bp_max",     m_max, 16'h8000);
            check("bp_idx",     m_idx, 0);
            check("bp_count",   m_count, 1);
        end
        consume();
        check("bp_valid_drop", m_valid, 0);
        check("bp_s_ready_back", s_ready, 1);

        // Overflow on the IDXW=2 instance
        send(16'd1, 0, 0);
        send(16'd2, 0, 0);
        send(16'd3, 0, 0);
        send(16'd4, 0, 0);
        send(16'd9, 0, 0);
        send(16'd0, 1, 0);
        check("o_valid", m_valid_s, 1);
        check("o_max",   m_max_s, 9);
        check("o_idx",   m_idx_s, 0);
        check("o_count", m_count_s, 2);
        check("o_ovf",   m_ovf_s, 1);
        check("o_big_idx",   m_idx, 4);
        check("o_big_count", m_count, 6);
        check("o_big_ovf",   m_ovf, 0);
        consume();
        send(16'd6, 1, 0);
        check("o2_ovf",   m_ovf_s, 0);
        check("o2_count", m_count_s, 1);
        check("o2_max",   m_max_s, 6);
        consume();

        // Reset mid-frame
        send(16'd8, 0, 0);
        send(16'd9, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rm_max",     m_max, 0);
        check("rm_count",   m_count, 0);
        check("rm_idx",     m_idx, 0);
        check("rm_s_ready", s_ready, 0);
        check("rm_m_valid", m_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(16'd3, 0, 0);
        send(16'd1, 1, 0);
        check("rf_valid", m_valid, 1);
        check("rf_max",   m_max, 3);
        check("rf_idx",   m_idx, 0);
        check("rf_count", m_count, 2);
        check("rf_ovf",   m_ovf, 0);
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
